// File: rtl/bsg_tie_cfg_pkg.sv
// Shared types and constants for the configurable tie-value bank.
//   bsg_tie_cfg_state_e : commit FSM states
//   err_cause_*_lp      : identifiers for the two conditions that raise err_o
//   safe_clog2          : address width helper that never returns 0
package bsg_tie_cfg_pkg;

  typedef enum logic {
    e_idle,
    e_commit
  } bsg_tie_cfg_state_e;

  // Write rejected because the target channel is locked.
  localparam int unsigned err_cause_locked_lp   = 0;
  // Write rejected because the address is past the last channel.
  localparam int unsigned err_cause_bad_addr_lp = 1;

  function automatic int unsigned safe_clog2(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_tie_cfg_chan.sv
// One tie channel: shadow register, active (driven) register and lock flag.
//   clk, reset : clock, synchronous active-high reset
//   we         : accepted write targets this channel
//   data, mask : write data and per-bit enable
//   lock       : set the lock flag along with this write
//   copy       : load active register from shadow on this edge
//   o          : active tie value
//   locked     : lock flag
module bsg_tie_cfg_chan #(
  parameter int unsigned            width_p     = 16,
  parameter logic [width_p-1:0]     reset_val_p = '1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [width_p-1:0] data,
  input  logic [width_p-1:0] mask,
  input  logic               lock,
  input  logic               copy,
  output logic [width_p-1:0] o,
  output logic               locked
);

  logic [width_p-1:0] shadow;

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow <= reset_val_p;
      o      <= reset_val_p;
      locked <= 1'b0;
    end else begin
      // A locked channel ignores both data and further lock requests.
      if (we && !locked) begin
        shadow <= (shadow & ~mask) | (data & mask);
        if (lock)
          locked <= 1'b1;
      end
      if (copy)
        o <= shadow;
    end
  end

endmodule

// File: rtl/bsg_tie_cfg_bank.sv
// Bank of els_p programmable static tie values with atomic commit.
//   clk_i, reset_i : clock, synchronous active-high reset
//   v_i / ready_o  : write request handshake
//   addr_i         : target channel
//   data_i, mask_i : write data and per-bit write enable
//   lock_i         : lock target channel after this write
//   commit_i       : copy all shadows to the outputs
//   o              : active tie values, channel k at o[k*width_p +: width_p]
//   locked_o       : per-channel lock status
//   err_o          : one-cycle pulse after a write to a locked/absent channel
module bsg_tie_cfg_bank
  import bsg_tie_cfg_pkg::*;
#(
  parameter int unsigned        width_p     = 16,
  parameter int unsigned        els_p       = 4,
  parameter logic [width_p-1:0] reset_val_p = '1,
  localparam int unsigned       lg_els_lp   = safe_clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     v_i,
  output logic                     ready_o,
  input  logic [lg_els_lp-1:0]     addr_i,
  input  logic [width_p-1:0]       data_i,
  input  logic [width_p-1:0]       mask_i,
  input  logic                     lock_i,
  input  logic                     commit_i,
  output logic [els_p*width_p-1:0] o,
  output logic [els_p-1:0]         locked_o,
  output logic                     err_o
);

  localparam logic [lg_els_lp:0] els_lp = (lg_els_lp+1)'(els_p);

  bsg_tie_cfg_state_e state, state_n;

  logic             accept;
  logic             bad_addr;
  logic             hit_locked;
  logic             copy;
  logic [els_p-1:0] sel;

  assign ready_o  = ~reset_i & (state == e_idle);
  assign accept   = v_i & ready_o;
  assign bad_addr = ({1'b0, addr_i} >= els_lp);
  // Writes are only accepted in IDLE, so shadows are stable during COMMIT.
  assign copy     = (state == e_commit);

  always_ff @(posedge clk_i) begin
    if (reset_i)
      state <= e_idle;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      e_idle:   if (commit_i) state_n = e_commit;
      e_commit: state_n = e_idle;
      default:  state_n = e_idle;
    endcase
  end

  for (genvar k = 0; k < els_p; k++) begin : g_chan
    assign sel[k] = accept & (addr_i == lg_els_lp'(k));

    bsg_tie_cfg_chan #(
      .width_p     (width_p),
      .reset_val_p (reset_val_p)
    ) chan (
      .clk    (clk_i),
      .reset  (reset_i),
      .we     (sel[k]),
      .data   (data_i),
      .mask   (mask_i),
      .lock   (lock_i),
      .copy   (copy),
      .o      (o[k*width_p +: width_p]),
      .locked (locked_o[k])
    );
  end

  // sel is already zero for out-of-range addresses, so this is safe for any addr_i.
  assign hit_locked = |(sel & locked_o);

  always_ff @(posedge clk_i) begin
    if (reset_i)
      err_o <= 1'b0;
    else
      err_o <= accept & (bad_addr | hit_locked);
  end

endmodule

// File: tb/tb_bsg_tie_cfg_bank.sv
module tb_bsg_tie_cfg_bank;

  logic        clk = 1'b0;
  logic        reset_i;

  // Default-configuration instance: 4 channels x 16 bits
  logic        v_i, ready_o, lock_i, commit_i, err_o;
  logic [1:0]  addr_i;
  logic [15:0] data_i, mask_i;
  logic [63:0] o;
  logic [3:0]  locked_o;

  // Three-channel instance for out-of-range address coverage
  logic        b_v, b_ready, b_lock, b_commit, b_err;
  logic [1:0]  b_addr;
  logic [15:0] b_data, b_mask;
  logic [47:0] b_o;
  logic [2:0]  b_locked;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  bsg_tie_cfg_bank dut (
    .clk_i    (clk),
    .reset_i  (reset_i),
    .v_i      (v_i),
    .ready_o  (ready_o),
    .addr_i   (addr_i),
    .data_i   (data_i),
    .mask_i   (mask_i),
    .lock_i   (lock_i),
    .commit_i (commit_i),
    .o        (o),
    .locked_o (locked_o),
    .err_o    (err_o)
  );

  bsg_tie_cfg_bank #(
    .width_p (16),
    .els_p   (3)
  ) dut3 (
    .clk_i    (clk),
    .reset_i  (reset_i),
    .v_i      (b_v),
    .ready_o  (b_ready),
    .addr_i   (b_addr),
    .data_i   (b_data),
    .mask_i   (b_mask),
    .lock_i   (b_lock),
    .commit_i (b_commit),
    .o        (b_o),
    .locked_o (b_locked),
    .err_o    (b_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d, input logic [15:0] m,
                    input logic lk);
    v_i = 1'b1; addr_i = a; data_i = d; mask_i = m; lock_i = lk;
  endtask

  task automatic idle_in();
    v_i = 1'b0; lock_i = 1'b0; commit_i = 1'b0; mask_i = '0; data_i = '0; addr_i = '0;
    b_v = 1'b0; b_lock = 1'b0; b_commit = 1'b0; b_mask = '0; b_data = '0; b_addr = '0;
  endtask

  initial begin
    reset_i = 1'b1;
    idle_in();
    #1;
    chk("ready_in_reset", 64'(ready_o), 64'd0);
    chk("ready3_in_reset", 64'(b_ready), 64'd0);
    tick();
    tick();
    reset_i = 1'b0;
    #1;

    // Defaults after reset
    chk("rst_o", o, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_locked", 64'(locked_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_o3", 64'(b_o), 64'h0000_FFFF_FFFF_FFFF);

    // Masked write to ch2, not visible until commit
    wr(2'd2, 16'h1234, 16'h00FF, 1'b0);
    tick();
    idle_in();
    chk("wr_no_commit_o", o, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("wr_err", 64'(err_o), 64'd0);
    commit_i = 1'b1;
    tick();                       // edge M: into COMMIT
    commit_i = 1'b0;
    #1;
    chk("commit_ready_low", 64'(ready_o), 64'd0);
    chk("commit_o_pending", o, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();                       // edge M+1: outputs load
    chk("commit_o", o, 64'hFFFF_FF34_FFFF_FFFF);
    chk("commit_ready_back", 64'(ready_o), 64'd1);

    // Simultaneous write and commit on ch0
    wr(2'd0, 16'h0000, 16'hFFFF, 1'b0);
    commit_i = 1'b1;
    tick();
    idle_in();
    #1;
    chk("simul_o_pending", o, 64'hFFFF_FF34_FFFF_FFFF);
    chk("simul_ready_low", 64'(ready_o), 64'd0);
    tick();
    chk("simul_o", o, 64'hFFFF_FF34_FFFF_0000);

    // Lock ch1, then try to overwrite it
    wr(2'd1, 16'hA5A5, 16'hFFFF, 1'b1);
    tick();
    idle_in();
    chk("lock_set", 64'(locked_o), 64'b0010);
    chk("lock_wr_err0", 64'(err_o), 64'd0);
    wr(2'd1, 16'h0000, 16'hFFFF, 1'b0);
    #1;
    chk("locked_ready", 64'(ready_o), 64'd1);
    tick();
    idle_in();
    chk("locked_err_pulse", 64'(err_o), 64'd1);
    chk("locked_still", 64'(locked_o), 64'b0010);
    tick();
    chk("locked_err_clear", 64'(err_o), 64'd0);
    // Lock-only operation on ch3 with zero mask
    wr(2'd3, 16'h0000, 16'h0000, 1'b1);
    tick();
    idle_in();
    chk("lock_only", 64'(locked_o), 64'b1010);
    chk("lock_only_err", 64'(err_o), 64'd0);
    commit_i = 1'b1;
    tick();
    commit_i = 1'b0;
    tick();
    chk("lock_commit_o", o, 64'hFFFF_FF34_A5A5_0000);

    // Out-of-range address on the 3-channel bank
    b_v = 1'b1; b_addr = 2'd3; b_data = 16'h0000; b_mask = 16'hFFFF; b_lock = 1'b1;
    tick();
    idle_in();
    chk("bad_addr_err", 64'(b_err), 64'd1);
    chk("bad_addr_locked", 64'(b_locked), 64'd0);
    tick();
    chk("bad_addr_err_clear", 64'(b_err), 64'd0);
    b_commit = 1'b1;
    tick();
    b_commit = 1'b0;
    tick();
    chk("bad_addr_o", 64'(b_o), 64'h0000_FFFF_FFFF_FFFF);
    // A valid write on the same bank still works
    b_v = 1'b1; b_addr = 2'd2; b_data = 16'h5A00; b_mask = 16'hFF00;
    b_commit = 1'b1;
    tick();
    idle_in();
    tick();
    chk("bank3_wr_o", 64'(b_o), 64'h0000_5AFF_FFFF_FFFF);
    chk("bank3_err", 64'(b_err), 64'd0);

    // Reset during COMMIT
    wr(2'd2, 16'h0000, 16'hFFFF, 1'b0);
    tick();
    idle_in();
    commit_i = 1'b1;
    tick();                       // now in COMMIT
    commit_i = 1'b0;
    reset_i = 1'b1;
    tick();
    chk("midrst_o", o, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("midrst_locked", 64'(locked_o), 64'd0);
    chk("midrst_ready", 64'(ready_o), 64'd0);
    reset_i = 1'b0;
    #1;
    chk("midrst_idle", 64'(ready_o), 64'd1);
    commit_i = 1'b1;
    tick();
    commit_i = 1'b0;
    tick();
    chk("midrst_shadow_reset", o, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("midrst_err", 64'(err_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
